sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared SRAM definitions used by the arbiter, the SRAM driver and fifo_extmem.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_BITS = 17;
  localparam int unsigned SRAM_DATA_BITS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sram_state_e;

  function automatic logic [1:0] port_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selection: round-robin on a registered last-served pointer,
// or fixed priority to port 1 when ROUND_ROBIN is 0.
module rr_arbiter2
  import sram_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic [1:0] gnt_o
);

  logic last_q;  // 1 = port 1 was served most recently

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = port_onehot(!(ROUND_ROBIN && last_q));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b0;
    end else if (take_i) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM driver: port 0 ingests (writes),
// port 1 plays back (reads). One transfer at a time, with a busy-cycle timeout.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = SRAM_ADDR_BITS,
  parameter int unsigned DATA_BITS      = SRAM_DATA_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter bit          ROUND_ROBIN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [DATA_BITS-1:0] wdata0,
  input  logic [DATA_BITS-1:0] wdata1,
  output logic [1:0]           done,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 timeout,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [DATA_BITS-1:0] mem_data_out,
  input  logic [DATA_BITS-1:0] mem_data_in,
  input  logic                 mem_completed
);

  localparam int unsigned         CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  sram_state_e          state_q;
  logic [1:0]           owner_q;
  logic [1:0]           gnt;
  logic [CNT_BITS-1:0]  cnt_q;
  logic                 mem_wr_en_q, mem_rd_en_q, timeout_q;
  logic [1:0]           done_q;
  logic [DATA_BITS-1:0] rdata_q, wdata_q, wdata_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 we_d;
  logic                 take;

  assign take = (state_q == IDLE) && (req != 2'b00);

  rr_arbiter2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .clk_i  (clk),
    .rst_i  (reset),
    .req_i  (req),
    .take_i (take),
    .gnt_o  (gnt)
  );

  always_comb begin
    addr_d  = gnt[1] ? addr1  : addr0;
    wdata_d = gnt[1] ? wdata1 : wdata0;
    we_d    = gnt[1] ? we[1]  : we[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      cnt_q       <= '0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      done_q      <= '0;
      timeout_q   <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      done_q    <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q     <= BUSY;
            owner_q     <= gnt;
            cnt_q       <= '0;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_wr_en_q <= we_d;
            mem_rd_en_q <= !we_d;
          end
        end
        BUSY: begin
          // A completion on the last allowed cycle wins over the timeout.
          if (mem_completed) begin
            state_q     <= IDLE;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            done_q      <= owner_q;
            if (mem_rd_en_q) rdata_q <= mem_data_in;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            done_q      <= owner_q;
            timeout_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done         = done_q;
  assign timeout      = timeout_q;
  assign rdata        = rdata_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_address  = addr_q;
  assign mem_data_out = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: requesters and an SRAM driver model
// produce expectations; a negedge monitor checks grants, holds and completions.
module tb_sram_arbiter;

  localparam int unsigned AB = 17;
  localparam int unsigned DB = 8;
  localparam int unsigned TO = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [AB-1:0] addr0 = '0, addr1 = '0;
  logic [DB-1:0] wdata0 = '0, wdata1 = '0;
  logic [DB-1:0] mem_data_in = '0;
  logic          mem_completed = 1'b0;
  logic [1:0]    done;
  logic [DB-1:0] rdata;
  logic          timeout, mem_wr_en, mem_rd_en;
  logic [AB-1:0] mem_address;
  logic [DB-1:0] mem_data_out;

  sram_arbiter #(
    .ADDR_BITS      (AB),
    .DATA_BITS      (DB),
    .TIMEOUT_CYCLES (TO),
    .ROUND_ROBIN    (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .we            (we),
    .addr0         (addr0),
    .addr1         (addr1),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .done          (done),
    .rdata         (rdata),
    .timeout       (timeout),
    .mem_wr_en     (mem_wr_en),
    .mem_rd_en     (mem_rd_en),
    .mem_address   (mem_address),
    .mem_data_out  (mem_data_out),
    .mem_data_in   (mem_data_in),
    .mem_completed (mem_completed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic          w;
    logic [AB-1:0] a;
    logic [DB-1:0] d;
  } grant_t;

  typedef struct {
    bit            to;
    int            lat;
    logic [DB-1:0] data;
  } outc_t;

  grant_t        gq[$];
  outc_t         oq[$];
  int            gl[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            last_srv = 0;
  int            last_run = 0;
  logic [DB-1:0] rd_model = '0;
  logic [AB-1:0] cur_addr[2];
  logic [DB-1:0] cur_wdata[2];
  logic          cur_we[2];
  int            force_lat = 0;
  bit            force_data_en = 1'b0;
  logic [DB-1:0] force_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_req(input int p, input logic [AB-1:0] a, input logic [DB-1:0] d);
    int cyc;
    @(negedge clk); #1;
    cur_addr[p] = a; cur_wdata[p] = d; cur_we[p] = (p == 0);
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
    we[p]  = (p == 0);
    req[p] = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (done[p] == 1'b0 && cyc < 300);
    if (done[p] == 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL req_wait port %0d: got no done after %0d cycles expected done", p, cyc);
    end
    #1 req[p] = 1'b0;
  endtask

  task automatic requester(input int p, input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      do_req(p, AB'($urandom), DB'($urandom));
    end
  endtask

  // SRAM driver model: counts enable-high cycles, completes after its chosen latency
  initial begin : drv
    bit            busy;
    int            cnt, lat;
    logic [DB-1:0] dat;
    outc_t         o;
    busy = 1'b0; cnt = 0; lat = 0; dat = '0;
    forever begin
      @(negedge clk); #1;
      mem_completed = 1'b0;
      if (reset) begin busy = 1'b0; continue; end
      if (mem_wr_en || mem_rd_en) begin
        if (!busy) begin
          busy = 1'b1; cnt = 0;
          if (force_lat != 0) lat = (force_lat < 0) ? 0 : force_lat;
          else begin
            case ($urandom_range(0, 9))
              0:       lat = 0;
              1:       lat = TO;
              default: lat = $urandom_range(1, 8);
            endcase
          end
          dat    = force_data_en ? force_data : DB'($urandom);
          o.to   = (lat == 0);
          o.lat  = lat;
          o.data = dat;
          oq.push_back(o);
        end
        cnt++;
        if (lat != 0 && cnt == lat) begin
          mem_completed = 1'b1; mem_data_in = dat; busy = 1'b0;
        end
      end else begin
        busy = 1'b0;
        if ($urandom_range(0, 5) == 0) begin
          mem_completed = 1'b1; mem_data_in = DB'($urandom);
        end
      end
    end
  end

  initial begin : mon
    logic   en, en_prev;
    int     run_len, ep;
    grant_t g, gc;
    outc_t  o;
    en_prev = 1'b0; run_len = 0;
    gc = '{port: 0, w: 1'b0, a: '0, d: '0};
    forever begin
      @(negedge clk);
      en = mem_wr_en | mem_rd_en;
      if (reset) begin
        gq.delete(); oq.delete(); gl.delete();
        last_srv = 0; rd_model = '0; en_prev = 1'b0; run_len = 0;
        continue;
      end
      chk("wr_rd_exclusive", 32'(mem_wr_en & mem_rd_en), 0);
      if (en && !en_prev) begin
        if (req == 2'b11) ep = (last_srv == 1) ? 0 : 1;
        else if (req[1]) ep = 1;
        else if (req[0]) ep = 0;
        else ep = -1;
        if (ep < 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_grant: got enable with req=%b expected no grant", req);
        end else begin
          gc = '{port: ep, w: cur_we[ep], a: cur_addr[ep], d: cur_wdata[ep]};
          gq.push_back(gc);
          gl.push_back(ep);
          last_srv = ep;
          chk("grant_wr_en", 32'(mem_wr_en), 32'(gc.w));
          chk("grant_rd_en", 32'(mem_rd_en), 32'(!gc.w));
          chk("grant_addr", 32'(mem_address), 32'(gc.a));
          chk("grant_wdata", 32'(mem_data_out), 32'(gc.d));
        end
        run_len = 1;
      end else if (en) begin
        run_len++;
        chk("hold_wr_en", 32'(mem_wr_en), 32'(gc.w));
        chk("hold_addr", 32'(mem_address), 32'(gc.a));
        chk("hold_wdata", 32'(mem_data_out), 32'(gc.d));
      end
      chk("done_at_enable_fall", 32'(done != 2'b00), 32'(en_prev && !en));
      chk("timeout_without_done", 32'(timeout && done == 2'b00), 0);
      if (done != 2'b00) begin
        if (gq.size() == 0 || oq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=%b expected no completion pending", done);
        end else begin
          g = gq.pop_front();
          o = oq.pop_front();
          chk("done_port", 32'(done), (g.port == 1) ? 32'd2 : 32'd1);
          chk("timeout_flag", 32'(timeout), 32'(o.to));
          chk("enable_cycles", 32'(run_len), o.to ? TO : 32'(o.lat));
          last_run = run_len;
          if (!g.w && !o.to) rd_model = o.data;
          chk("rdata", 32'(rdata), 32'(rd_model));
        end
      end
      en_prev = en;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got time limit expected bench completion");
    $fatal(1, "bench did not complete");
  end

  initial begin : main
    int cyc;
    int exp_g[4];
    exp_g = '{1, 0, 1, 0};
    cur_addr = '{default: '0}; cur_wdata = '{default: '0}; cur_we = '{default: 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done", 32'(done), 0);
    chk("reset_timeout", 32'(timeout), 0);
    chk("reset_rdata", 32'(rdata), 0);
    chk("reset_wr_en", 32'(mem_wr_en), 0);
    chk("reset_rd_en", 32'(mem_rd_en), 0);
    chk("reset_addr", 32'(mem_address), 0);
    chk("reset_wdata", 32'(mem_data_out), 0);
    #2 reset = 1'b0;

    force_lat = 20;
    do_req(0, 17'h00010, 8'hA5);
    chk("write_done", 32'(done), 32'h1);
    chk("write_timeout", 32'(timeout), 0);
    chk("write_enable_cycles", 32'(last_run), 20);

    force_lat = 3; force_data_en = 1'b1; force_data = 8'h3C;
    do_req(1, 17'h1FFFF, 8'h00);
    chk("read_done", 32'(done), 32'h2);
    chk("read_rdata", 32'(rdata), 32'h3C);

    force_data_en = 1'b0; force_lat = -1;
    do_req(0, 17'h00123, 8'h5A);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_done", 32'(done), 32'h1);
    chk("to_enable_cycles", 32'(last_run), TO);
    chk("to_rdata_kept", 32'(rdata), 32'h3C);

    force_lat = 0;
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
    fork
      requester(0, 2, 0);
      requester(1, 2, 0);
    join
    if (gl.size() < 4) begin
      n_cmp++; n_bad++;
      $display("FAIL rr_grant_count: got %0d expected 4", gl.size());
    end else begin
      for (int i = 0; i < 4; i++) chk("rr_grant_order", 32'(gl[i]), 32'(exp_g[i]));
    end

    fork
      requester(0, 40, 4);
      requester(1, 40, 4);
    join

    force_lat = -1;
    @(negedge clk); #1;
    cur_addr[0] = 17'h0ABCD; cur_wdata[0] = 8'h77; cur_we[0] = 1'b1;
    addr0 = 17'h0ABCD; wdata0 = 8'h77; we[0] = 1'b1; req[0] = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(mem_wr_en || mem_rd_en) && cyc < 50);
    chk("rst_busy_reached", 32'(mem_wr_en), 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr_en", 32'(mem_wr_en), 0);
    chk("rst_mid_rd_en", 32'(mem_rd_en), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_rdata", 32'(rdata), 0);
    #2 reset = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    chk("rst_after_done", 32'(done), 0);
    force_lat = 4;
    fork
      do_req(0, 17'h00001, 8'h11);
      do_req(1, 17'h00002, 8'h22);
    join
    if (gl.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rst_first_grant: got no grant expected port 1");
    end else begin
      chk("rst_first_grant", 32'(gl[0]), 1);
    end

    repeat (5) @(negedge clk);
    chk("grant_queue_drained", 32'(gq.size()), 0);
    chk("outcome_queue_drained", 32'(oq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
